vx_cache_perf_ctrl: RTL and testbench

//  Owns the eight cache performance counters (reads, writes, read/write misses, bank/MSHR/mem/core-rsp

---
 rtl/vx_perf_pkg.sv | 22 ++
 rtl/vx_perf_sat_ctr.sv | 42 ++++
 rtl/vx_cache_perf_ctrl.sv | 133 +++++++++++++
 tb/tb_vx_cache_perf_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_perf_pkg.sv
// Shared definitions for the cache performance counter block: counter index map and snapshot FSM states.
package vx_perf_pkg;

   typedef enum logic [2:0] {
      READS        = 3'd0,
      WRITES       = 3'd1,
      READ_MISSES  = 3'd2,
      WRITE_MISSES = 3'd3,
      BANK_STALLS  = 3'd4,
      MSHR_STALLS  = 3'd5,
      MEM_STALLS   = 3'd6,
      CRSP_STALLS  = 3'd7
   } perf_cache_idx_e;

   localparam int PERF_CACHE_NCTR = 8;

   typedef enum logic {
      SNAP_IDLE   = 1'b0,
      SNAP_STREAM = 1'b1
   } snap_state_e;

endpackage

// File: rtl/vx_perf_sat_ctr.sv
// Saturating event counter: adds a small popcount each enabled cycle, clear has priority, never wraps.
module vx_perf_sat_ctr #(
   parameter int WIDTH   = 44,
   parameter int IN_BITS = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [IN_BITS-1:0] inc_i,
   output logic [WIDTH-1:0]   cnt_d_o,
   output logic [WIDTH-1:0]   cnt_q_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH:0]   sum;

   // One guard bit catches the carry out so the counter pins at all-ones.
   assign sum = {1'b0, cnt_q} + {{(WIDTH + 1 - IN_BITS){1'b0}}, inc_i};

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_d_o = cnt_d;
   assign cnt_q_o = cnt_q;

endmodule

// File: rtl/vx_cache_perf_ctrl.sv
// Cache performance counter owner: eight saturating counters, a live counter bus and an
// eight-beat snapshot read-out towards the CSR unit.
module vx_cache_perf_ctrl
   import vx_perf_pkg::*;
#(
   parameter int NUM_BANKS = 4,
   parameter int CTR_BITS  = 44
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_BANKS-1:0]      ev_read,
   input  logic [NUM_BANKS-1:0]      ev_write,
   input  logic [NUM_BANKS-1:0]      ev_read_miss,
   input  logic [NUM_BANKS-1:0]      ev_write_miss,
   input  logic [NUM_BANKS-1:0]      ev_bank_stall,
   input  logic                      ev_mshr_stall,
   input  logic                      ev_mem_stall,
   input  logic                      ev_crsp_stall,
   input  logic                      cnt_enable,
   input  logic                      cnt_clear,
   output logic [8*CTR_BITS-1:0]     ctr_live,
   input  logic                      snap_valid,
   output logic                      snap_ready,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [2:0]                rsp_idx,
   output logic [CTR_BITS-1:0]       rsp_data,
   output logic                      rsp_last
);

   localparam int IN_BITS = $clog2(NUM_BANKS + 1);

   logic [IN_BITS-1:0]  inc   [PERF_CACHE_NCTR];
   logic [CTR_BITS-1:0] ctr_d [PERF_CACHE_NCTR];
   logic [CTR_BITS-1:0] ctr_q [PERF_CACHE_NCTR];
   logic [CTR_BITS-1:0] snap_q[PERF_CACHE_NCTR];

   snap_state_e state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        capture;

   always_comb begin
      for (int i = 0; i < PERF_CACHE_NCTR; i++) begin
         inc[i] = '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         inc[READS]        = inc[READS]        + IN_BITS'(ev_read[b]);
         inc[WRITES]       = inc[WRITES]       + IN_BITS'(ev_write[b]);
         inc[READ_MISSES]  = inc[READ_MISSES]  + IN_BITS'(ev_read_miss[b]);
         inc[WRITE_MISSES] = inc[WRITE_MISSES] + IN_BITS'(ev_write_miss[b]);
         inc[BANK_STALLS]  = inc[BANK_STALLS]  + IN_BITS'(ev_bank_stall[b]);
      end
      inc[MSHR_STALLS] = IN_BITS'(ev_mshr_stall);
      inc[MEM_STALLS]  = IN_BITS'(ev_mem_stall);
      inc[CRSP_STALLS] = IN_BITS'(ev_crsp_stall);
   end

   for (genvar g = 0; g < PERF_CACHE_NCTR; g++) begin : g_ctr
      vx_perf_sat_ctr #(
         .WIDTH   (CTR_BITS),
         .IN_BITS (IN_BITS)
      ) u_ctr (
         .clk     (clk),
         .reset_n (reset_n),
         .en_i    (cnt_enable),
         .clr_i   (cnt_clear),
         .inc_i   (inc[g]),
         .cnt_d_o (ctr_d[g]),
         .cnt_q_o (ctr_q[g])
      );
      assign ctr_live[g*CTR_BITS +: CTR_BITS] = ctr_q[g];
   end

   // Handshakes: a transfer happens on a cycle where both valid and ready are high;
   // rsp_idx/rsp_data/rsp_last stay frozen while rsp_valid is high and rsp_ready is low.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      snap_ready = 1'b0;
      rsp_valid  = 1'b0;
      capture    = 1'b0;
      case (state_q)
         SNAP_IDLE: begin
            snap_ready = 1'b1;
            if (snap_valid) begin
               capture = 1'b1;
               idx_d   = 3'd0;
               state_d = SNAP_STREAM;
            end
         end
         SNAP_STREAM: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd0;
                  state_d = SNAP_IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = SNAP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SNAP_IDLE;
         idx_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Snapshot takes the post-update values so it matches what ctr_live shows next cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PERF_CACHE_NCTR; i++) begin
            snap_q[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < PERF_CACHE_NCTR; i++) begin
            snap_q[i] <= ctr_d[i];
         end
      end
   end

   assign rsp_idx  = idx_q;
   assign rsp_data = snap_q[idx_q];
   assign rsp_last = rsp_valid & (idx_q == 3'd7);

endmodule

// File: tb/tb_vx_cache_perf_ctrl.sv
// Bench for vx_cache_perf_ctrl: a 44-bit and a 4-bit instance share stimulus; a behavioural
// model predicts live counters and snapshot beats are scored through an expected queue.
module tb_vx_cache_perf_ctrl;

  localparam int NB = 4;
  localparam int CB = 44;
  localparam int CS = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] ev_read, ev_write, ev_read_miss, ev_write_miss, ev_bank_stall;
  logic          ev_mshr_stall, ev_mem_stall, ev_crsp_stall;
  logic          cnt_enable, cnt_clear, snap_valid, rsp_ready;

  logic [8*CB-1:0] ctr_live;
  logic            snap_ready, rsp_valid, rsp_last;
  logic [2:0]      rsp_idx;
  logic [CB-1:0]   rsp_data;

  logic [8*CS-1:0] ctr_live_s;
  logic            snap_ready_s, rsp_valid_s, rsp_last_s;
  logic [2:0]      rsp_idx_s;
  logic [CS-1:0]   rsp_data_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] exp_q[$];
  longint unsigned m_big[8];
  longint unsigned m_small[8];
  bit m_stream;
  int m_beat;

  always #5 clk = ~clk;

  vx_cache_perf_ctrl #(.NUM_BANKS(NB), .CTR_BITS(CB)) u_dut (
    .clk(clk), .reset_n(reset_n), .ev_read(ev_read), .ev_write(ev_write),
    .ev_read_miss(ev_read_miss), .ev_write_miss(ev_write_miss), .ev_bank_stall(ev_bank_stall),
    .ev_mshr_stall(ev_mshr_stall), .ev_mem_stall(ev_mem_stall), .ev_crsp_stall(ev_crsp_stall),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .ctr_live(ctr_live),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_idx(rsp_idx), .rsp_data(rsp_data), .rsp_last(rsp_last)
  );

  vx_cache_perf_ctrl #(.NUM_BANKS(NB), .CTR_BITS(CS)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .ev_read(ev_read), .ev_write(ev_write),
    .ev_read_miss(ev_read_miss), .ev_write_miss(ev_write_miss), .ev_bank_stall(ev_bank_stall),
    .ev_mshr_stall(ev_mshr_stall), .ev_mem_stall(ev_mem_stall), .ev_crsp_stall(ev_crsp_stall),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .ctr_live(ctr_live_s),
    .snap_valid(snap_valid), .snap_ready(snap_ready_s), .rsp_valid(rsp_valid_s),
    .rsp_ready(rsp_ready), .rsp_idx(rsp_idx_s), .rsp_data(rsp_data_s), .rsp_last(rsp_last_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned sat_add(longint unsigned cur, int inc, int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (cur + longint'(inc) > mx) ? mx : cur + longint'(inc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_big[i]   = 0;
      m_small[i] = 0;
    end
    exp_q.delete();
    m_stream = 0;
    m_beat   = 0;
  endtask

  task automatic check_live(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_live%0d", tag, i), 64'(ctr_live[i*CB +: CB]), m_big[i]);
      check($sformatf("%s_small%0d", tag, i), 64'(ctr_live_s[i*CS +: CS]), m_small[i]);
    end
  endtask

  // One clock: score outputs at the falling edge, advance the model, then step past the rising edge.
  task automatic tick();
    int inc[8];
    logic [47:0] got, e;
    #4;
    check("snap_ready", 64'(snap_ready), 64'(!m_stream));
    check("rsp_valid", 64'(rsp_valid), 64'(m_stream));
    if (m_stream) begin
      got = {rsp_idx, rsp_last, rsp_data};
      e   = (exp_q.size() > 0) ? exp_q[0] : '1;
      if (rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("beat", 64'(got), 64'(e));
      end else begin
        check("beat_hold", 64'(got), 64'(e));
      end
    end
    inc[0] = $countones(ev_read);
    inc[1] = $countones(ev_write);
    inc[2] = $countones(ev_read_miss);
    inc[3] = $countones(ev_write_miss);
    inc[4] = $countones(ev_bank_stall);
    inc[5] = int'(ev_mshr_stall);
    inc[6] = int'(ev_mem_stall);
    inc[7] = int'(ev_crsp_stall);
    for (int i = 0; i < 8; i++) begin
      if (cnt_clear) begin
        m_big[i]   = 0;
        m_small[i] = 0;
      end else if (cnt_enable) begin
        m_big[i]   = sat_add(m_big[i], inc[i], CB);
        m_small[i] = sat_add(m_small[i], inc[i], CS);
      end
    end
    if (!m_stream && snap_valid) begin
      for (int i = 0; i < 8; i++) begin
        e = {i[2:0], (i == 7), m_big[i][CB-1:0]};
        exp_q.push_back(e);
      end
      m_stream = 1;
      m_beat   = 0;
    end else if (m_stream && rsp_ready) begin
      if (m_beat == 7) m_stream = 0;
      else m_beat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (m_stream && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_drain_in_budget"}, 64'(n < 40), 64'd1);
  endtask

  task automatic random_events();
    ev_read       = NB'($urandom_range(0, 15));
    ev_write      = NB'($urandom_range(0, 15));
    ev_read_miss  = NB'($urandom_range(0, 15));
    ev_write_miss = NB'($urandom_range(0, 15));
    ev_bank_stall = NB'($urandom_range(0, 15));
    ev_mshr_stall = 1'($urandom_range(0, 1));
    ev_mem_stall  = 1'($urandom_range(0, 1));
    ev_crsp_stall = 1'($urandom_range(0, 1));
  endtask

  task automatic quiet_events();
    ev_read = '0; ev_write = '0; ev_read_miss = '0; ev_write_miss = '0; ev_bank_stall = '0;
    ev_mshr_stall = 1'b0; ev_mem_stall = 1'b0; ev_crsp_stall = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    quiet_events();
    cnt_enable = 1'b1; cnt_clear = 1'b0; snap_valid = 1'b0; rsp_ready = 1'b0;
    model_reset();
    #3;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_snap_ready", 64'(snap_ready), 64'd1);
    check("rst_rsp_idx", 64'(rsp_idx), 64'd0);
    check_live("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reads accumulate popcount 3 per cycle.
    ev_read = 4'b1011;
    repeat (5) tick();
    quiet_events();
    check("t1_reads", 64'(ctr_live[0 +: CB]), 64'd15);
    check_live("t1");

    // Small instance pins at 15, large keeps counting.
    ev_write = 4'b1111;
    repeat (5) tick();
    quiet_events();
    repeat (3) tick();
    check("t2_small_sat", 64'(ctr_live_s[1*CS +: CS]), 64'd15);
    check("t2_big_writes", 64'(ctr_live[1*CB +: CB]), 64'd20);
    check_live("t2");

    // Clear wins over a same-cycle increment.
    ev_read_miss = 4'b0011;
    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    quiet_events();
    check("t3_clear", 64'(ctr_live[2*CB +: CB]), 64'd0);
    check_live("t3");

    // Disabled counting drops events, then random traffic on every counter.
    cnt_enable = 1'b0;
    ev_read = 4'hf; ev_bank_stall = 4'hf; ev_mshr_stall = 1'b1;
    repeat (3) tick();
    check_live("dis");
    cnt_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      random_events();
      tick();
      check_live("rnd");
    end
    quiet_events();

    // Snapshot with READS preloaded to 7, full-rate read-out.
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    ev_read = 4'b0111;
    tick();
    ev_read = 4'b1111;
    tick();
    ev_read = '0;
    check("t4_reads_pre", 64'(ctr_live[0 +: CB]), 64'd7);
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    check("t4_beat0_data", 64'(rsp_data), 64'd7);
    check("t4_beat0_idx", 64'(rsp_idx), 64'd0);
    drain("t4");
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Stalled read-out while counting and occasional clears continue.
    ev_read = 4'b0101;
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 60 && m_stream; k++) begin
      rsp_ready = ~rsp_ready;
      random_events();
      cnt_clear = ($urandom_range(0, 7) == 0);
      tick();
    end
    cnt_clear = 1'b0;
    check("t5_done", 64'(m_stream), 64'd0);
    check_live("t5");

    // snap_valid held high: the next snapshot is accepted right after the last beat.
    snap_valid = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) tick();
    snap_valid = 1'b0;
    drain("t5b");
    quiet_events();

    // Reset in the middle of a read-out.
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("t6_at_beat3", 64'(rsp_idx), 64'd3);
    reset_n = 1'b0;
    #2;
    model_reset();
    check("t6_rst_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_ready", 64'(snap_ready), 64'd1);
    check_live("t6");
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    check("t6_snap_ready", 64'(snap_ready), 64'd1);
    ev_write = 4'b0110;
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    quiet_events();
    check("t6_new_idx0", 64'(rsp_idx), 64'd0);
    check("t6_new_writes", 64'(ctr_live[1*CB +: CB]), 64'd2);
    drain("t6");
    check_live("end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
